// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: register map, CTRL/STATUS bit positions, swap FSM states and 640x480@50MHz timing constants
package vga_fb_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_POS = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam int CTRL_SWAP = 0;
  localparam int CTRL_EN = 1;
  localparam int STAT_PEND = 0;
  localparam int STAT_FRONT = 1;
  localparam int STAT_VBLANK = 2;
  localparam int STAT_FRAME = 16;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int HTOTAL = 2 * (640 + H_FP + H_SYNC + H_BP);
  localparam int VTOTAL = 480 + V_FP + V_SYNC + V_BP;
  typedef enum logic {IDLE, PENDING} swap_state_t;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running hcount (2 clk per pixel) / vcount counters with hs, vs, blank_n decode; in clk/reset, out counters and decoded syncs
module vga_timing
  import vga_fb_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int HFP = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int VFP = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int HTOT = HTOTAL,
  parameter int VTOT = VTOTAL,
  parameter int HW = $clog2(HTOT),
  parameter int VW = $clog2(VTOT)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hs,
  output logic          vs,
  output logic          blank_n
);
  logic h_end;
  assign h_end = hcount == HW'(HTOT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= h_end ? '0 : hcount + 1'b1;
      if (h_end) vcount <= (vcount == VW'(VTOT - 1)) ? '0 : vcount + 1'b1;
    end
  assign hs = !(32'(hcount) >= 2 * (H_ACTIVE + HFP) && 32'(hcount) < 2 * (H_ACTIVE + HFP + HSYNC));
  assign vs = !(32'(vcount) >= V_ACTIVE + VFP && 32'(vcount) < V_ACTIVE + VFP + VSYNC);
  assign blank_n = 32'(hcount) < 2 * H_ACTIVE && 32'(vcount) < V_ACTIVE;
endmodule

// File: rtl/vga_framebuffer.sv
// vga_framebuffer: Avalon-MM 8-bit grayscale framebuffer with optional vblank-synchronised double buffering; in clk/reset + Avalon slave, out readdata + VGA DAC signals
module vga_framebuffer
  import vga_fb_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DOUBLE_BUF = 1,
  parameter int HFP = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HBP = H_BP,
  parameter int VFP = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VBP = V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_n,
  output logic        VGA_SYNC_n
);
  localparam int WORDS = H_ACTIVE * V_ACTIVE / 4;
  localparam int AW = $clog2(WORDS);
  localparam int HTOT = 2 * (H_ACTIVE + HFP + HSYNC + HBP);
  localparam int VTOT = V_ACTIVE + VFP + VSYNC + VBP;
  localparam int HW = $clog2(HTOT);
  localparam int VW = $clog2(VTOT);
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic hs, vs, blank_n;
  logic [AW-1:0] wptr, scan_addr;
  logic [1:0] scan_lane;
  logic front, back, en;
  swap_state_t state;
  logic [15:0] frame;
  logic [31:0] mem [2][WORDS];
  logic [31:0] status, pix_idx;
  logic [15:0] pos_x, pos_y;
  logic wr, in_vblank, vblank_start, swap_req;
  logic [1:0] hs_d, vs_d, bl_d, ck_d;
  logic [7:0] pixel;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .HFP(HFP), .HSYNC(HSYNC),
    .VFP(VFP), .VSYNC(VSYNC), .HTOT(HTOT), .VTOT(VTOT)
  ) u_timing (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hs(hs), .vs(vs), .blank_n(blank_n)
  );
  assign wr = chipselect && write;
  assign pos_x = writedata[31:16];
  assign pos_y = writedata[15:0];
  assign back = (DOUBLE_BUF != 0) && !front;
  assign swap_req = wr && address == REG_CTRL && writedata[CTRL_SWAP] && DOUBLE_BUF != 0;
  assign in_vblank = 32'(vcount) >= V_ACTIVE;
  assign vblank_start = 32'(vcount) == V_ACTIVE && hcount == '0;
  assign pix_idx = 32'(vcount) * H_ACTIVE + 32'(hcount[HW-1:1]);
  always_comb begin
    status = '0;
    status[STAT_PEND] = state == PENDING;
    status[STAT_FRONT] = front;
    status[STAT_VBLANK] = in_vblank;
    status[STAT_FRAME +: 16] = frame;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      readdata <= '0;
      wptr <= '0;
      en <= 1'b1;
    end else begin
      readdata <= (chipselect && read && address == REG_STATUS) ? status : '0;
      if (wr && address == REG_DATA) wptr <= (32'(wptr) == WORDS - 1) ? '0 : wptr + 1'b1;
      if (wr && address == REG_POS && 32'(pos_x) < H_ACTIVE && 32'(pos_y) < V_ACTIVE)
        wptr <= AW'((32'(pos_y) * H_ACTIVE + 32'(pos_x)) >> 2);
      if (wr && address == REG_CTRL) en <= writedata[CTRL_EN];
    end
  // A swap request landing on the vblank-start cycle wins over the clear, so it waits a full frame.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      front <= 1'b0;
      frame <= '0;
    end else begin
      if (vblank_start) frame <= frame + 1'b1;
      if (vblank_start && state == PENDING) front <= !front;
      state <= swap_req ? PENDING : (vblank_start ? IDLE : state);
    end
  always_ff @(posedge clk)
    if (wr && address == REG_DATA) mem[back][wptr] <= writedata;
  // Two-stage scan: address/lane register, then RAM read + lane select; syncs ride a matching 2-deep delay.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      scan_addr <= '0;
      scan_lane <= '0;
      pixel <= '0;
      hs_d <= 2'b11;
      vs_d <= 2'b11;
      bl_d <= 2'b11;
      ck_d <= 2'b00;
    end else begin
      scan_addr <= blank_n ? AW'(pix_idx >> 2) : '0;
      scan_lane <= pix_idx[1:0];
      pixel <= (bl_d[0] && en) ? mem[front][scan_addr][{scan_lane, 3'b000} +: 8] : '0;
      hs_d <= {hs_d[0], hs};
      vs_d <= {vs_d[0], vs};
      bl_d <= {bl_d[0], blank_n};
      ck_d <= {ck_d[0], hcount[0]};
    end
  assign VGA_R = pixel;
  assign VGA_G = pixel;
  assign VGA_B = pixel;
  assign VGA_HS = hs_d[1];
  assign VGA_VS = vs_d[1];
  assign VGA_BLANK_n = bl_d[1];
  assign VGA_CLK = ck_d[1];
  assign VGA_SYNC_n = 1'b0;
endmodule

// File: doc/vga_framebuffer.md
# vga_framebuffer

Parametrised Avalon-MM VGA framebuffer peripheral, successor to the single-buffer 8-bit grayscale display block. It holds one or two on-chip frame buffers of packed 8-bit luminance pixels, four per 32-bit word. Software writes pixels through an auto-incrementing pointer, and the block scans the front buffer out to the VGA DAC. With double buffering, a buffer swap requested by software takes effect only at the start of vertical blank, giving tear-free updates.

## Interface
- H_ACTIVE, 640, visible pixels per line; multiple of 4.
- V_ACTIVE, 480, visible lines.
- DOUBLE_BUF, 1, 1 = two buffers with swap; 0 = single buffer, swap ignored.
- WORDS, H_ACTIVE*V_ACTIVE/4 (derived), words per buffer; AW = $clog2(WORDS).
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high.
- chipselect, write, read  in  1  Avalon-MM slave strobes.
- address  in  2  word address.
- writedata  in  32  write data.
- readdata  out  32  read data, 1-cycle read latency.
- VGA_R, VGA_G, VGA_B  out  8  each equals the pixel luminance.
- VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n  out  1  DAC clock and sync. VGA_SYNC_n is tied 0.

## Operation
- Register map (word address):
  - 0 DATA (W): stores writedata at wptr in the back buffer. Byte lane k holds pixel 4*wptr+k. wptr then increments and wraps to 0 after WORDS-1.
  - 1 POS (W): x = writedata[31:16], y = writedata[15:0]. Sets wptr = (y*H_ACTIVE+x)>>2. Ignored if x>=H_ACTIVE or y>=V_ACTIVE.
  - 2 CTRL (W): bit0 = 1 sets swap_pending; bit1 = display enable (reset value 1).
  - 3 STATUS (R): bit0 swap_pending, bit1 front index, bit2 in_vblank, [31:16] frame counter.
  - Reads of any other address return 0.
- Back buffer = !front when DOUBLE_BUF=1. When DOUBLE_BUF=0, both front and back are buffer 0, and swap_pending is never set.
- Vblank-start event: the cycle where vcount==V_ACTIVE and hcount==0. On this event:
  - if swap_pending: front <= !front and swap_pending <= 0.
  - frame counter increments; it wraps at 16 bits.
- A CTRL swap write in the same cycle as vblank-start sets swap_pending. That swap occurs at the next frame's vblank-start.
- Scan-out timing is the standard 640x480 at 50 MHz: hcount 0..1599 with each pixel lasting 2 clk, vcount 0..524. Sync and blank decoding are identical to the existing counter block.
- Scan-out reads word (vcount*H_ACTIVE + hcount[10:1])>>2 of the front buffer and selects lane hcount[10:1][1:0].
- Output pixel is 0 when blanked or when display enable = 0.
- Each buffer is a simple dual-port RAM: one write port on the bus side, one read port on the scan side. No read/write conflicts are possible across buffers. Writing the front buffer in single-buffer mode returns either the old or the new data.

## Timing
- Reset values:
  - VGA_R/G/B = 0, readdata = 0.
  - wptr, front, swap_pending, frame counter, hcount, vcount all 0.
  - VGA_HS = VGA_VS = 1; VGA_BLANK_n follows the counters.
- Scan pipeline is 2 clk: address register, then RAM read plus lane select register.
- HS, VS, BLANK_n and VGA_CLK come from hcount/vcount delayed 2 clk, so they align exactly with the pixel data.
- A DATA write is visible to scan-out from the next cycle onward. wptr updates in the cycle after the write strobe.
- Reset asserted mid-frame clears everything asynchronously. Scan-out restarts at pixel (0,0).

## Structure
- Package vga_fb_pkg holds:
  - register address constants REG_DATA, REG_POS, REG_CTRL, REG_STATUS;
  - CTRL/STATUS bit positions;
  - horizontal/vertical timing localparams (HTOTAL=1600, VTOTAL=525, porches, sync widths).
- Sub-module vga_timing: counters plus sync/blank decode. It takes H_ACTIVE/V_ACTIVE and the package timing.
- Top level contains the register file, wptr logic, swap FSM (IDLE/PENDING), buffer RAM instances and the scan pipeline.

## Test plan
- Write POS x=4,y=0 (0x00040000), then DATA 0x44332211 → pixels (4..7,0) output 0x11,0x22,0x33,0x44. RGB equals the pixel value 2 clk after the matching hcount.
- Write POS x=636,y=479, then two DATA writes → the second lands at word 0. STATUS is unchanged.
- Write POS x=640,y=0 → wptr unchanged; the next DATA lands at the prior wptr.
- DOUBLE_BUF=1: fill back buffer with 0xFF, write CTRL=3 mid-frame → STATUS bit0 reads 1. At vblank-start, front reads 1 and bit0 reads 0. The next frame scans 0xFF.
- CTRL swap write coincident with vblank-start → front unchanged this frame; it toggles at the following vblank-start. The frame counter increments by 2 across the sequence.
- CTRL=0 (display disabled) → RGB = 0 across the whole frame while HS/VS continue. Assert reset mid-line → all outputs return to reset values immediately.
